// File: rtl/mips32_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mips32_mem_arbiter_if
//   Bundles the signals between the core's fetch and load/store ports, the
//   arbiter, and the single-ported unified memory.
//
//   Modports:
//     slave  - the arbiter. It takes the fetch/data requests and memory
//              responses, and drives the grants, read data, the memory
//              command and the stall.
//     master - the core plus memory side. It is the mirror image of slave.
//
//   Fetch port : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   Data port  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   Memory     : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
//   Core       : cpu_stall
// ----------------------------------------------------------------------------
interface mips32_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          cpu_stall;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output cpu_stall
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  cpu_stall
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// mips32_mem_arbiter
//   Shares one single-ported unified memory between instruction fetch and
//   load/store. A winning request is latched and driven onto the memory
//   port. The arbiter then waits as long as needed for mem_ready and returns
//   read data (or a store acknowledge) to the winner. Data normally wins a
//   tie. After STARVE_LIMIT consecutive lost ties, fetch wins the next one.
//
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - mips32_mem_arbiter_if.slave (fetch, data, memory and stall)
//
//   Every output except cpu_stall is registered. cpu_stall is combinational,
//   so the core can freeze in the same cycle that it raises a request.
// ----------------------------------------------------------------------------
module mips32_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mips32_mem_arbiter_if.slave      bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_gnt_q, if_gnt_d;
    logic          d_gnt_q, d_gnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          grant_i;
    logic          grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        // Fetch takes a tie only once it has been starved up to the limit.
        grant_i = bus.if_req & (~bus.d_req | (starve_q == LIMIT));
        grant_d = bus.d_req & ~grant_i;

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    if_gnt_d    = 1'b1;
                end else if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    d_gnt_d     = 1'b1;
                end

                // A fetch that is waiting and loses counts toward starvation.
                // Any fetch grant, or the fetch going away, resets the count.
                if (!bus.if_req || grant_i) begin
                    starve_d = '0;
                end else if (grant_d && starve_q != LIMIT) begin
                    starve_d = starve_q + 4'd1;
                end
            end

            BUSY_I: begin
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    if_rdata_d  = bus.mem_rdata;
                    if_rvalid_d = 1'b1;
                end
            end

            BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    d_rvalid_d = 1'b1;
                    // A store acknowledge leaves the last load data in place.
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // A requester is stalled until it sees its own rvalid.
    assign bus.cpu_stall = (bus.if_req & ~if_rvalid_q) | (bus.d_req & ~d_rvalid_q);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mips32_mem_arbiter
//   Directed bench for mips32_mem_arbiter. Inputs change 1 ns after each
//   rising edge, and outputs are sampled at that same point. A "cycle" here
//   is the interval that follows a rising edge.
// ----------------------------------------------------------------------------
module tb_mips32_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mips32_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mips32_mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_mem_req",   bus.mem_req,   0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_if_rdata",  bus.if_rdata,  0);
        check("rst_d_rdata",   bus.d_rdata,   0);
        check("rst_gnts",      {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid}, 0);
        check("rst_stall",     bus.cpu_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single fetch with mem_ready tied high.
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0040;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h8C08_0004;
        #1;
        check("f_stall_c0", bus.cpu_stall, 1);
        tick();
        check("f_if_gnt",   bus.if_gnt,   1);
        check("f_mem_req",  bus.mem_req,  1);
        check("f_mem_addr", bus.mem_addr, 32'h40);
        check("f_mem_we",   bus.mem_we,   0);
        check("f_rvalid_c1", bus.if_rvalid, 0);
        tick();
        check("f_if_rvalid", bus.if_rvalid, 1);
        check("f_if_rdata",  bus.if_rdata,  32'h8C08_0004);
        check("f_stall_c2",  bus.cpu_stall, 0);
        check("f_gnt_c2",    bus.if_gnt,    0);
        check("f_req_c2",    bus.mem_req,   0);
        bus.if_req = 1'b0;

        // Spurious mem_ready in IDLE with no requests.
        bus.mem_rdata = 32'h5555_5555;
        tick();
        check("sp_rvalid_a", {bus.if_rvalid, bus.d_rvalid}, 0);
        tick();
        check("sp_rvalid_b", {bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt}, 0);
        check("sp_mem_req",  bus.mem_req,  0);
        check("sp_if_rdata", bus.if_rdata, 32'h8C08_0004);

        // A load first, so that d_rdata holds something a store must not touch.
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h200;
        bus.mem_rdata = 32'h1234_5678;
        tick();
        check("ld_d_gnt",    bus.d_gnt,    1);
        check("ld_mem_addr", bus.mem_addr, 32'h200);
        tick();
        check("ld_d_rvalid", bus.d_rvalid, 1);
        check("ld_d_rdata",  bus.d_rdata,  32'h1234_5678);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Store with two wait states; mem_ready is high only on the 3rd BUSY cycle.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        check("st_d_gnt", bus.d_gnt, 1);
        for (int i = 1; i <= 3; i++) begin
            check("st_mem_req",   bus.mem_req,   1);
            check("st_mem_we",    bus.mem_we,    1);
            check("st_mem_addr",  bus.mem_addr,  32'h100);
            check("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            check("st_no_rvalid", bus.d_rvalid,  0);
            bus.d_addr  = 32'h999;
            bus.d_wdata = 32'h0BAD_0BAD;
            if (i == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hAAAA_5555;
            end
            tick();
            if (i < 3) check("st_gnt_once", bus.d_gnt, 0);
        end
        check("st_d_rvalid", bus.d_rvalid, 1);
        check("st_d_rdata",  bus.d_rdata,  32'h1234_5678);
        check("st_req_clr",  {bus.mem_req, bus.mem_we}, 0);
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        tick();
        check("st_rvalid_1", bus.d_rvalid, 0);

        // Contention with alternation: d, i, d, i.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h1000;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.mem_rdata = 32'h0000_0011;
        tick();
        check("c1_gnt",  {bus.d_gnt, bus.if_gnt}, 2'b10);
        check("c1_addr", bus.mem_addr, 32'h2000);
        tick();
        check("c1_rv", bus.d_rvalid, 1);
        bus.d_req = 1'b0;
        tick();
        check("c2_gnt",  {bus.d_gnt, bus.if_gnt}, 2'b01);
        check("c2_addr", bus.mem_addr, 32'h1000);
        bus.d_req = 1'b1;
        tick();
        check("c2_rv", bus.if_rvalid, 1);
        bus.if_req = 1'b0;
        tick();
        check("c3_gnt", {bus.d_gnt, bus.if_gnt}, 2'b10);
        bus.if_req = 1'b1;
        tick();
        check("c3_rv", bus.d_rvalid, 1);
        bus.d_req = 1'b0;
        tick();
        check("c4_gnt", {bus.d_gnt, bus.if_gnt}, 2'b01);
        tick();
        check("c4_rv", bus.if_rvalid, 1);
        bus.if_req = 1'b0;
        tick();
        tick();

        // Starvation: both held; data wins 4 ties, fetch wins the 5th.
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("sv_d_gnt", {bus.d_gnt, bus.if_gnt}, 2'b10);
            tick();
            check("sv_d_rv", bus.d_rvalid, 1);
        end
        tick();
        check("sv_if_gnt_5th", {bus.d_gnt, bus.if_gnt}, 2'b01);
        tick();
        check("sv_if_rv", bus.if_rvalid, 1);
        bus.if_req = 1'b0;
        tick();
        check("sv_d_next", {bus.d_gnt, bus.if_gnt}, 2'b10);
        tick();
        bus.d_req = 1'b0;
        tick();

        // Reset while BUSY_D with mem_ready low.
        bus.mem_ready = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h300;
        tick();
        check("rm_gnt", bus.d_gnt, 1);
        tick();
        check("rm_busy", bus.mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_mem_req",  bus.mem_req,  0);
        check("rm_mem_addr", bus.mem_addr, 0);
        check("rm_rdata",    {bus.if_rdata, bus.d_rdata}, 0);
        check("rm_rvalid",   {bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt}, 0);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        check("rm_rv_in_rst", bus.d_rvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("rm_idle_req", bus.mem_req, 0);
        check("rm_idle_out", {bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt}, 0);

        // Requester drops d_req the cycle after d_gnt.
        bus.mem_ready = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h400;
        tick();
        check("dr_gnt", bus.d_gnt, 1);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        tick();
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        check("dr_rv",    bus.d_rvalid,  1);
        check("dr_rdata", bus.d_rdata,   32'hCAFE_F00D);
        check("dr_stall", bus.cpu_stall, 1);
        tick();
        check("dr_next_gnt",  {bus.d_gnt, bus.if_gnt, bus.d_rvalid}, 3'b010);
        check("dr_next_addr", bus.mem_addr, 32'h500);
        tick();
        check("dr_if_rv", {bus.if_rvalid, bus.d_rvalid}, 2'b10);
        bus.if_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Arbitrates one single-ported unified memory between the core's instruction-fetch port and its load/store data port.
- Latches the winning request, drives the memory port and waits for a variable-latency ready. It returns read data or a write acknowledge to the winner and raises a stall to the core while any access is outstanding.
- Sits between the PC/fetch logic, the load/store path and the unified memory. It replaces the separate instruction and data memories so the datapath can run multi-cycle.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins a tie; valid range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_rvalid.
- if_addr  input  AW  fetch address.
- if_gnt  output  1  one-cycle pulse: fetch request latched.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DW  fetched instruction.
- d_req  input  1  data request; held high until d_rvalid.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_gnt  output  1  one-cycle pulse: data request latched.
- d_rvalid  output  1  one-cycle pulse: load data valid, or store done.
- d_rdata  output  DW  load data.
- mem_req  output  1  memory access active.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.
- mem_ready  input  1  memory completes the current access this cycle.
- cpu_stall  output  1  core must hold state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All outputs 0, including mem_addr, mem_wdata, if_rdata and d_rdata.
  - Starvation counter = 0.
  - Any in-flight memory access is abandoned with no rvalid.
- States: IDLE, BUSY_I, BUSY_D. All outputs except cpu_stall are registered.
- IDLE, arbitration on each edge:
  - Neither request: stay in IDLE.
  - Only one request: that requester wins.
  - Both requests: data wins, unless the starvation counter equals STARVE_LIMIT, in which case fetch wins.
  - Winner actions: latch addr, we and wdata; set mem_req=1, mem_we (0 for fetch), mem_addr and mem_wdata; pulse the winner's gnt for one cycle; go to BUSY_I or BUSY_D.
- Starvation counter (4-bit, saturating at STARVE_LIMIT):
  - Increments on every IDLE edge where if_req=1 and data wins.
  - Clears when fetch is granted or when if_req=0 in IDLE.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant.
  - Edge with mem_ready=1: x_rdata <= mem_rdata (loads and fetches only; d_rdata is unchanged on a store), x_rvalid pulses for one cycle, mem_req and mem_we clear to 0, go to IDLE.
  - mem_ready=0: stay in BUSY_x, with no timeout.
- Latency and throughput:
  - Request seen at edge N gives gnt and mem_req during cycle N+1.
  - With mem_ready high in N+1, rvalid is high in N+2.
  - Minimum spacing is 2 cycles per access; there is no back-to-back grant without an IDLE cycle.
- mem_ready is ignored in IDLE.
- Changes to x_req, addr or data inputs after gnt are ignored until the access completes. If x_req drops mid-access, rvalid still pulses.
- cpu_stall (combinational) = (if_req & ~if_rvalid) | (d_req & ~d_rvalid).
- Simultaneous if_req and d_req when the counter is at the limit: fetch is granted and the counter clears. Data is served on the next IDLE edge.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040, mem_ready tied 1, mem_rdata=0x8C08_0004 -> if_gnt in cycle 1 with mem_addr=0x40 and mem_we=0; if_rvalid with if_rdata=0x8C08_0004 in cycle 2; cpu_stall low in cycle 2.
- Store with wait states: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, mem_ready high only on the 3rd BUSY cycle -> mem_req, mem_we, mem_addr and mem_wdata stable for 3 cycles; a single d_rvalid pulse follows; d_rdata unchanged.
- Contention: if_req and d_req both held high, mem_ready=1 -> data is granted first. Then verify the exact sequence: d, i, d, i (the requester that completed drops req for one cycle). With d_req held permanently high, fetch is granted on the 5th contested arbitration (STARVE_LIMIT=4).
- Reset mid-access: assert rst_n=0 while in BUSY_D with mem_ready=0 -> all outputs 0 immediately, with no d_rvalid. After release with no requests, the block stays IDLE with mem_req=0.
- Requester drops req after gnt: d_req falls the cycle after d_gnt -> the access still completes; d_rvalid pulses once and the next arbitration sees only the remaining requesters.
- Spurious mem_ready=1 in IDLE with no requests -> no rvalid pulses and no state change.
